// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store unit in front of a word-addressed data memory.
// Loads are byte, halfword or word with sign or zero extension. Word stores take one
// write cycle. Byte and halfword stores use a read-modify-write: the word is read and
// merged in the accept cycle, and written back in RMW_WR.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When it is defined, a misaligned access
// returns an error. When it is not defined, the address is forced aligned.
module load_store_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic {IDLE, RMW_WR} state_t;

   state_t      state, state_nxt;
   logic [31:0] rmw_addr, rmw_data;

   logic        accept;
   logic        is_rmw;
   logic        sz_byte, sz_half, sz_word;
   logic        illegal, misalign, err;
   logic [31:0] eff_addr, word_addr;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data, merged;

   // Decode the request: access size, illegal codes, alignment and effective address.
   always_comb begin
      sz_byte = (req_funct3[1:0] == 2'b00);
      sz_half = (req_funct3[1:0] == 2'b01);
      sz_word = (req_funct3[1:0] == 2'b10);
      // Loads allow 000/001/010/100/101; stores allow only 000/001/010.
      if (req_load)
         illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
      else
         illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
      misalign = (sz_half & req_addr[0]) | (sz_word & (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
      err      = illegal | misalign;
      eff_addr = req_addr;
`else
      // The offset bits below the access size are dropped, so the access stays
      // inside the addressed word.
      err      = illegal;
      eff_addr = {req_addr[31:2], req_addr[1] & ~sz_word, req_addr[0] & sz_byte};
`endif
      word_addr = {eff_addr[31:2], 2'b00};
   end

   // Select the load lane from the read word and extend it to 32 bits.
   always_comb begin
      case (eff_addr[1:0])
         2'b00:   byte_sel = mem_rdata[7:0];
         2'b01:   byte_sel = mem_rdata[15:8];
         2'b10:   byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = eff_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (req_funct3)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b010:  load_data = mem_rdata;
         3'b100:  load_data = {24'h0, byte_sel};
         3'b101:  load_data = {16'h0, half_sel};
         default: load_data = 32'h0;
      endcase
   end

   // Merge the store byte or halfword into the word read in the accept cycle.
   always_comb begin
      merged = mem_rdata;
      if (sz_byte)
         merged[{eff_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
      else if (sz_half)
         merged[{eff_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
   end

   // Next state, handshake and memory strobes. The strobes are held at 0 while reset
   // is asserted, so an abandoned RMW can never write.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      accept    = 1'b0;
      is_rmw    = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      if (!rst_n) begin
         req_ready = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               req_ready = 1'b1;
               accept    = req_valid;
               if (accept && !err) begin
                  mem_addr = word_addr;
                  if (req_load) begin
                     mem_read = 1'b1;
                  end else if (sz_word) begin
                     mem_write = 1'b1;
                     mem_wdata = req_wdata;
                  end else begin
                     mem_read  = 1'b1;
                     is_rmw    = 1'b1;
                     state_nxt = RMW_WR;
                  end
               end
            end
            RMW_WR: begin
               mem_write = 1'b1;
               mem_addr  = rmw_addr;
               mem_wdata = rmw_data;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Capture the merged word and its address for the RMW write-back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rmw_addr <= 32'h0;
         rmw_data <= 32'h0;
      end else if (is_rmw) begin
         rmw_addr <= word_addr;
         rmw_data <= merged;
      end
   end

   // Registered response. A sub-word store responds after its write cycle;
   // every other access responds the cycle after accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
      end else begin
         resp_valid <= (accept & ~is_rmw) | (state == RMW_WR);
         resp_err   <= accept & err;
         resp_rdata <= (accept & ~err & req_load) ? load_data : 32'h0;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. A byte-array reference memory models the
// expected data. A word array stands in for the real data memory behind the DUT.
// Compile with LSU_MISALIGN_TRAP_EN defined to check the trapping build.
module tb_load_store_unit;

   logic        clk, rst_n;
   logic        req_valid, req_ready, req_load;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] dmem [0:255];
   logic [7:0]  ref_bytes [0:1023];
   logic        init_we;
   logic [7:0]  init_idx;
   logic [31:0] init_val;

   int vectors = 0;
   int miscompares = 0;

   load_store_unit dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory: combinational read, synchronous write, plus a preload port.
   assign mem_rdata = dmem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (init_we)        dmem[init_idx] <= init_val;
      else if (mem_write) dmem[mem_addr[9:2]] <= mem_wdata;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input int w);
      return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
   endfunction

   task automatic poke(input int w, input logic [31:0] v);
      init_we = 1'b1; init_idx = w[7:0]; init_val = v;
      @(posedge clk); #1;
      init_we = 1'b0;
      for (int k = 0; k < 4; k++) ref_bytes[4*w+k] = v[8*k +: 8];
   endtask

   // Issue one access from an idle unit and check strobes, latency and response.
   task automatic do_req(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] got);
      logic ill, mis, e, wsz, hsz, rmw;
      logic [31:0] ae, exp_rd;
      logic [7:0]  b0, b1, b2, b3;
      int nbytes;
      wsz = (f3[1:0] == 2'd2);
      hsz = (f3[1:0] == 2'd1);
      ill = ld ? !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : !(f3 inside {3'd0, 3'd1, 3'd2});
      mis = (hsz && a[0]) || (wsz && (a % 4 != 0));
`ifdef LSU_MISALIGN_TRAP_EN
      e  = ill | mis;
      ae = a;
`else
      e  = ill;
      ae = hsz ? a - (a % 2) : (wsz ? a - (a % 4) : a);
`endif
      b0 = ref_bytes[ae[9:0]];
      b1 = ref_bytes[(ae[9:0] + 10'd1)];
      b2 = ref_bytes[(ae[9:0] + 10'd2)];
      b3 = ref_bytes[(ae[9:0] + 10'd3)];
      exp_rd = 32'h0;
      if (ld && !e) begin
         case (f3)
            3'd0: exp_rd = 32'($signed(b0));
            3'd1: exp_rd = 32'($signed({b1, b0}));
            3'd2: exp_rd = {b3, b2, b1, b0};
            3'd4: exp_rd = 32'(b0);
            3'd5: exp_rd = 32'({b1, b0});
            default: exp_rd = 32'h0;
         endcase
      end
      rmw = !ld && !e && !wsz;

      req_valid = 1'b1; req_load = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
      #1;
      chk("acc_ready", req_ready, 1'b1);
      chk("acc_rd", mem_read, !e && (ld || rmw));
      chk("acc_wr", mem_write, !e && !ld && wsz);
      chk("acc_addr", mem_addr, e ? 32'h0 : ae - (ae % 4));
      if (!e && !ld && wsz) chk("sw_wdata", mem_wdata, wd);
      @(posedge clk); #1;
      // The unit must not rely on held request fields after accept.
      req_valid = 1'b0; req_load = $urandom; req_funct3 = $urandom;
      req_addr = $urandom; req_wdata = $urandom;
      if (!ld && !e) begin
         nbytes = wsz ? 4 : (hsz ? 2 : 1);
         for (int k = 0; k < nbytes; k++) ref_bytes[ae[9:0] + 10'(k)] = wd[8*k +: 8];
      end
      if (rmw) begin
         chk("rmw_ready", req_ready, 1'b0);
         chk("rmw_wr", mem_write, 1'b1);
         chk("rmw_rd", mem_read, 1'b0);
         chk("rmw_addr", mem_addr, ae - (ae % 4));
         chk("rmw_wdata", mem_wdata, ref_word(ae[9:2]));
         chk("rmw_early", resp_valid, 1'b0);
         @(posedge clk); #1;
      end
      chk("resp_valid", resp_valid, 1'b1);
      chk("resp_err", resp_err, e);
      chk("resp_rdata", resp_rdata, exp_rd);
      got = resp_rdata;
      @(posedge clk); #1;
      chk("resp_pulse", resp_valid, 1'b0);
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] saved;
      rst_n = 1'b0; req_valid = 1'b0; req_load = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'h0; req_wdata = 32'h0; init_we = 1'b0; init_idx = 8'h0; init_val = 32'h0;
      #1;
      chk("rst_ready", req_ready, 1'b1);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_mem_rd", mem_read, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      for (int w = 0; w < 256; w++) poke(w, $urandom);
      poke(32'h40, 32'h8899AABC);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Loads from 0x8899AABC at 0x100.
      do_req(1'b1, 3'd0, 32'h103, 32'h0, got); chk("lb_103", got, 32'hFFFFFF88);
      do_req(1'b1, 3'd4, 32'h103, 32'h0, got); chk("lbu_103", got, 32'h00000088);
      do_req(1'b1, 3'd1, 32'h102, 32'h0, got); chk("lh_102", got, 32'hFFFF8899);
      do_req(1'b1, 3'd2, 32'h100, 32'h0, got); chk("lw_100", got, 32'h8899AABC);

      // Sub-word RMW store followed by a read-back.
      do_req(1'b0, 3'd0, 32'h101, 32'h55, got);
      do_req(1'b1, 3'd2, 32'h100, 32'h0, got); chk("lw_after_sb", got, 32'h889955BC);

      // Word store, then misaligned and illegal codes.
      do_req(1'b0, 3'd2, 32'h200, 32'hDEADBEEF, got);
      chk("sw_mem", dmem[32'h200 >> 2], 32'hDEADBEEF);
      do_req(1'b1, 3'd2, 32'h102, 32'h0, got);
`ifndef LSU_MISALIGN_TRAP_EN
      chk("lw_102_forced", got, 32'h889955BC);
`endif
      do_req(1'b1, 3'd3, 32'h100, 32'h0, got);
      do_req(1'b0, 3'd3, 32'h100, 32'h1, got);
      do_req(1'b0, 3'd5, 32'h104, 32'h1, got);

      // A load presented during RMW_WR waits, then sees the written byte.
      req_valid = 1'b1; req_load = 1'b0; req_funct3 = 3'd0; req_addr = 32'h100; req_wdata = 32'hF0;
      @(posedge clk); #1;
      ref_bytes[10'h100] = 8'hF0;
      req_load = 1'b1; req_wdata = 32'h0;
      chk("b2b_ready_lo", req_ready, 1'b0);
      chk("b2b_wr", mem_write, 1'b1);
      @(posedge clk); #1;
      chk("b2b_sb_resp", resp_valid, 1'b1);
      chk("b2b_lb_rd", mem_read, 1'b1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("b2b_lb_resp", resp_valid, 1'b1);
      chk("b2b_lb_data", resp_rdata, 32'hFFFFFFF0);
      @(posedge clk); #1;

      // Asynchronous reset while a response is visible and a request is pending.
      req_valid = 1'b1; req_load = 1'b1; req_funct3 = 3'd2; req_addr = 32'h200;
      @(posedge clk); #1;
      chk("pre_rst_resp", resp_rdata, 32'hDEADBEEF);
      rst_n = 1'b0; #1;
      chk("arst_valid", resp_valid, 1'b0);
      chk("arst_rdata", resp_rdata, 32'h0);
      chk("arst_err", resp_err, 1'b0);
      chk("arst_rd", mem_read, 1'b0);
      chk("arst_addr", mem_addr, 32'h0);
      chk("arst_ready", req_ready, 1'b1);
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset during RMW_WR abandons the write.
      saved = ref_word(32'h204 >> 2);
      req_valid = 1'b1; req_load = 1'b0; req_funct3 = 3'd1; req_addr = 32'h204; req_wdata = 32'h1234;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("mrst_in_rmw", req_ready, 1'b0);
      rst_n = 1'b0; #1;
      chk("mrst_no_wr", mem_write, 1'b0);
      @(posedge clk); #1;
      chk("mrst_no_wr2", mem_write, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mrst_no_resp", resp_valid, 1'b0);
      chk("mrst_mem", dmem[32'h204 >> 2], saved);

      // Random accesses against the reference memory.
      for (int i = 0; i < 300; i++)
         do_req(1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 1023)), $urandom, got);

      for (int w = 0; w < 256; w++) chk("mem_final", dmem[w], ref_word(w));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
